// File: rtl/iob_clint_pkg.sv
// Shared constants and helpers for the core-local interruptor: register
// offsets inside the CLINT window (SiFive layout), timer width and the
// byte-strobe merge used by every writable 32-bit word.
package iob_clint_pkg;

    localparam int unsigned MSIP_BASE     = 32'h0000_0000;
    localparam int unsigned MTIMECMP_BASE = 32'h0000_4000;
    localparam int unsigned MTIME_LO      = 32'h0000_BFF8;
    localparam int unsigned MTIME_HI      = 32'h0000_BFFC;
    localparam int unsigned MTIME_W       = 64;

    // Replace the bytes of old_word selected by wstrb with the matching bytes of wdata.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_clint_timebase.sv
// Prescaler plus the 64-bit free-running mtime counter. A bus write to
// either half overrides the tick for that cycle: the written half takes the
// merged bytes, the other half keeps its old value and no carry is applied.
// The prescaler keeps running through mtime writes.
module iob_clint_timebase
    import iob_clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               cke,
    input  logic [31:0]        lo_wdata,
    input  logic [3:0]         lo_wstrb,
    input  logic [31:0]        hi_wdata,
    input  logic [3:0]         hi_wstrb,
    output logic [MTIME_W-1:0] mtime
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]   presc;
    logic               tick;
    logic               wr_any;
    logic [MTIME_W-1:0] mtime_q;

    assign tick   = cke && (presc == PRE_LAST);
    assign wr_any = (|lo_wstrb) || (|hi_wstrb);
    assign mtime  = mtime_q;

    // Prescaler: counts enabled cycles 0..TICK_DIV-1, wraps on tick.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            presc <= '0;
        end else if (cke) begin
            presc <= tick ? '0 : presc + PRE_W'(1);
        end
    end

    // mtime: bus write wins over the tick; otherwise increment modulo 2^64.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mtime_q <= '0;
        end else if (wr_any) begin
            mtime_q <= {merge_bytes(mtime_q[63:32], hi_wdata, hi_wstrb),
                        merge_bytes(mtime_q[31:0],  lo_wdata, lo_wstrb)};
        end else if (tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

endmodule

// File: rtl/iob_clint.sv
// Core-local interruptor on the CPU's CLINT IOb port: address decode,
// per-hart msip and mtimecmp banks, registered timer-compare flops and the
// registered read path. The timebase lives in iob_clint_timebase.
//
// Handshake: iob_ready_o is tied high, so any cycle with iob_avalid_i=1 and
// cke_i=1 is an accepted request. iob_wstrb_i nonzero means write (applied at
// the accepting edge, no response); zero means read, answered by
// iob_rvalid_o=1 for exactly the following cycle with iob_rdata_o valid.
// iob_rdata_o holds until the next read. Reset drops any pending response.
module iob_clint
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int N_CORES  = 1,
    parameter int TICK_DIV = 1
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                iob_ready_o,
    output logic [N_CORES-1:0]  mtip_o,
    output logic [N_CORES-1:0]  msip_o
);

    logic [ADDR_W-1:0]  waddr;
    logic               wr;
    logic               rd;
    logic [N_CORES-1:0] msip_sel;
    logic [N_CORES-1:0] cmp_lo_sel;
    logic [N_CORES-1:0] cmp_hi_sel;
    logic               mt_lo_sel;
    logic               mt_hi_sel;
    logic [3:0]         mt_lo_wstrb;
    logic [3:0]         mt_hi_wstrb;
    logic [MTIME_W-1:0] mtime;
    logic [MTIME_W-1:0] mtimecmp [N_CORES];
    logic [N_CORES-1:0] msip_q;
    logic [N_CORES-1:0] mtip_q;
    logic [31:0]        rd_mux;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q;

    // Word-aligned address: the byte lane bits are masked off.
    assign waddr = iob_addr_i & ~ADDR_W'(3);
    assign wr    = iob_avalid_i && cke_i && (|iob_wstrb_i);
    assign rd    = iob_avalid_i && cke_i && !(|iob_wstrb_i);

    assign iob_ready_o  = 1'b1;
    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;
    assign mtip_o       = mtip_q;
    assign msip_o       = msip_q;

    // Address decode; harts at or above N_CORES never match and read as 0.
    always_comb begin
        msip_sel   = '0;
        cmp_lo_sel = '0;
        cmp_hi_sel = '0;
        for (int h = 0; h < N_CORES; h++) begin
            msip_sel[h]   = (waddr == ADDR_W'(MSIP_BASE + 4*h));
            cmp_lo_sel[h] = (waddr == ADDR_W'(MTIMECMP_BASE + 8*h));
            cmp_hi_sel[h] = (waddr == ADDR_W'(MTIMECMP_BASE + 8*h + 4));
        end
        mt_lo_sel = (waddr == ADDR_W'(MTIME_LO));
        mt_hi_sel = (waddr == ADDR_W'(MTIME_HI));
    end

    assign mt_lo_wstrb = (wr && mt_lo_sel) ? iob_wstrb_i : 4'b0000;
    assign mt_hi_wstrb = (wr && mt_hi_sel) ? iob_wstrb_i : 4'b0000;

    iob_clint_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .clk      (clk_i),
        .arst_n   (arst_n_i),
        .cke      (cke_i),
        .lo_wdata (iob_wdata_i),
        .lo_wstrb (mt_lo_wstrb),
        .hi_wdata (iob_wdata_i),
        .hi_wstrb (mt_hi_wstrb),
        .mtime    (mtime)
    );

    // msip bank: only bit 0 is storage, written through byte lane 0.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            msip_q <= '0;
        end else begin
            for (int h = 0; h < N_CORES; h++) begin
                if (wr && msip_sel[h] && iob_wstrb_i[0]) begin
                    msip_q[h] <= iob_wdata_i[0];
                end
            end
        end
    end

    // mtimecmp bank: reset to all ones so no timer interrupt fires after reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int h = 0; h < N_CORES; h++) begin
                mtimecmp[h] <= '1;
            end
        end else begin
            for (int h = 0; h < N_CORES; h++) begin
                if (wr && cmp_lo_sel[h]) begin
                    mtimecmp[h][31:0] <= merge_bytes(mtimecmp[h][31:0], iob_wdata_i, iob_wstrb_i);
                end
                if (wr && cmp_hi_sel[h]) begin
                    mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], iob_wdata_i, iob_wstrb_i);
                end
            end
        end
    end

    // Timer compare: registered, uses current register values (one-cycle latency).
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mtip_q <= '0;
        end else if (cke_i) begin
            for (int h = 0; h < N_CORES; h++) begin
                mtip_q[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    // Read mux over pre-update register values; unmapped reads return 0.
    always_comb begin
        rd_mux = 32'h0;
        for (int h = 0; h < N_CORES; h++) begin
            if (msip_sel[h])   rd_mux = {31'h0, msip_q[h]};
            if (cmp_lo_sel[h]) rd_mux = mtimecmp[h][31:0];
            if (cmp_hi_sel[h]) rd_mux = mtimecmp[h][63:32];
        end
        if (mt_lo_sel) rd_mux = mtime[31:0];
        if (mt_hi_sel) rd_mux = mtime[63:32];
    end

    // Read response: one-cycle rvalid pulse, rdata held until the next read.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            rvalid_q <= rd;
            if (rd) begin
                rdata_q <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_iob_clint.sv
// Self-checking bench for iob_clint. Two instances share clock, reset and
// address/data/strobe lines: dut (TICK_DIV=1) and dut4 (TICK_DIV=4, own
// avalid and cke). Expected mtime comes from an arithmetic model: a base
// value plus the number of enabled edges since the last mtime write.
module tb_iob_clint;

    localparam logic [15:0] A_MSIP0   = 16'h0000;
    localparam logic [15:0] A_MSIP1   = 16'h0004;
    localparam logic [15:0] A_CMP_LO  = 16'h4000;
    localparam logic [15:0] A_CMP_HI  = 16'h4004;
    localparam logic [15:0] A_CMP1_LO = 16'h4008;
    localparam logic [15:0] A_MT_LO   = 16'hBFF8;
    localparam logic [15:0] A_MT_HI   = 16'hBFFC;
    localparam logic [15:0] A_UNMAP   = 16'h8000;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cke     = 1'b1;
    logic        cke4    = 1'b0;
    logic        avalid  = 1'b0;
    logic        avalid4 = 1'b0;
    logic [15:0] addr    = '0;
    logic [31:0] wdata   = '0;
    logic [3:0]  wstrb   = '0;
    logic        rvalid, ready, rvalid4, ready4;
    logic [31:0] rdata, rdata4;
    logic [0:0]  mtip, msip, mtip4, msip4;

    iob_clint #(.ADDR_W(16), .DATA_W(32), .N_CORES(1), .TICK_DIV(1)) dut (
        .clk_i        (clk),
        .arst_n_i     (rst_n),
        .cke_i        (cke),
        .iob_avalid_i (avalid),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_rvalid_o (rvalid),
        .iob_rdata_o  (rdata),
        .iob_ready_o  (ready),
        .mtip_o       (mtip),
        .msip_o       (msip)
    );

    iob_clint #(.ADDR_W(16), .DATA_W(32), .N_CORES(1), .TICK_DIV(4)) dut4 (
        .clk_i        (clk),
        .arst_n_i     (rst_n),
        .cke_i        (cke4),
        .iob_avalid_i (avalid4),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_rvalid_o (rvalid4),
        .iob_rdata_o  (rdata4),
        .iob_ready_o  (ready4),
        .mtip_o       (mtip4),
        .msip_o       (msip4)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp4_q[$];
    int          t = 0;
    int          t_base = 0;
    int          e4 = 0;
    logic [63:0] mt_base = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Read responses of dut are popped against the expected queue.
    always @(negedge clk) begin
        if (rvalid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("rvalid_spurious", {63'h0, rvalid}, 64'h0);
            end else begin
                check("rdata", {32'h0, rdata}, {32'h0, exp_q.pop_front()});
            end
        end
    end

    // Read responses of dut4.
    always @(negedge clk) begin
        if (rvalid4 !== 1'b0) begin
            if (exp4_q.size() == 0) begin
                check("rvalid4_spurious", {63'h0, rvalid4}, 64'h0);
            end else begin
                check("rdata4", {32'h0, rdata4}, {32'h0, exp4_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        if (rst_n && cke)  t++;
        if (rst_n && cke4) e4++;
        @(negedge clk);
    endtask

    function automatic logic [63:0] mt_now();
        return mt_base + 64'(t - t_base);
    endfunction

    task automatic bus_read(input logic [15:0] a, input logic [31:0] exp);
        addr   = a;
        wstrb  = 4'h0;
        avalid = 1'b1;
        exp_q.push_back(exp);
        step();
        avalid = 1'b0;
    endtask

    task automatic bus_read4(input logic [15:0] a, input logic [31:0] exp);
        addr    = a;
        wstrb   = 4'h0;
        avalid4 = 1'b1;
        exp4_q.push_back(exp);
        step();
        avalid4 = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        addr   = a;
        wdata  = d;
        wstrb  = s;
        avalid = 1'b1;
        step();
        avalid = 1'b0;
        wstrb  = 4'h0;
    endtask

    // Read an mtime half of dut; expected value is the pre-update model value.
    task automatic rd_mt(input logic [15:0] a);
        logic [63:0] m;
        m = mt_now();
        bus_read(a, a[2] ? m[63:32] : m[31:0]);
    endtask

    // Write an mtime half of dut and rebase the model: no increment that cycle.
    task automatic wr_mtime(input bit hi, input logic [31:0] d, input logic [3:0] s);
        logic [63:0] cur;
        logic [31:0] half;
        cur  = mt_now();
        half = hi ? cur[63:32] : cur[31:0];
        for (int b = 0; b < 4; b++) begin
            if (s[b]) half[8*b +: 8] = d[8*b +: 8];
        end
        bus_write(hi ? A_MT_HI : A_MT_LO, d, s);
        mt_base = hi ? {half, cur[31:0]} : {cur[63:32], half};
        t_base  = t;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", {63'h0, rvalid}, 64'h0);
        check("rst_rdata",  {32'h0, rdata},  64'h0);
        check("rst_ready",  {63'h0, ready},  64'h1);
        check("rst_mtip",   {63'h0, mtip},   64'h0);
        check("rst_msip",   {63'h0, msip},   64'h0);
        check("rst_rvalid4", {63'h0, rvalid4}, 64'h0);

        // Release reset; mtime counts from 0, one per cycle.
        rst_n = 1'b1;
        t = 0; t_base = 0; mt_base = '0; e4 = 0;
        rd_mt(A_MT_LO);               // 0
        rd_mt(A_MT_LO);               // 1 (back-to-back)
        rd_mt(A_MT_HI);               // 0
        bus_read(A_CMP_LO, 32'hFFFF_FFFF);
        bus_read(A_CMP_HI, 32'hFFFF_FFFF);
        rd_mt(16'hBFFA);              // byte-lane bits ignored
        check("ready_idle", {63'h0, ready}, 64'h1);

        // msip: set, strobe on wrong lane, upper bits read 0, clear.
        bus_write(A_MSIP0, 32'h1, 4'hF);
        check("msip_set", {63'h0, msip}, 64'h1);
        bus_read(A_MSIP0, 32'h1);
        bus_write(A_MSIP0, 32'h0, 4'b0010);
        check("msip_lane1_nochange", {63'h0, msip}, 64'h1);
        bus_write(A_MSIP0, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_MSIP0, 32'h1);
        bus_write(A_MSIP0, 32'h0, 4'b0001);
        check("msip_clear", {63'h0, msip}, 64'h0);
        bus_read(A_MSIP0, 32'h0);

        // Unmapped and hart-1 addresses: writes ignored, reads return 0.
        bus_write(A_MSIP1, 32'h1, 4'hF);
        check("msip_hart1_ignored", {63'h0, msip}, 64'h0);
        bus_read(A_MSIP1, 32'h0);
        bus_write(A_UNMAP, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_UNMAP, 32'h0);
        bus_read(A_CMP1_LO, 32'h0);
        bus_read(A_CMP_LO, 32'hFFFF_FFFF);

        // Timer interrupt: mtime=0x10, mtimecmp=0x20.
        wr_mtime(1'b0, 32'h10, 4'hF);
        wr_mtime(1'b1, 32'h0, 4'hF);
        bus_write(A_CMP_LO, 32'h20, 4'hF);
        bus_write(A_CMP_HI, 32'h0, 4'hF);
        check("mtip_early", {63'h0, mtip}, 64'h0);
        for (int i = 0; i < 64 && mt_now() != 64'h20; i++) step();
        check("mtip_at_cmp", {63'h0, mtip}, 64'h0);
        step();
        check("mtip_rise", {63'h0, mtip}, 64'h1);
        bus_write(A_CMP_HI, 32'h1, 4'hF);
        check("mtip_hold", {63'h0, mtip}, 64'h1);
        step();
        check("mtip_clear", {63'h0, mtip}, 64'h0);
        bus_read(A_CMP_HI, 32'h1);
        bus_write(A_CMP_LO, 32'hAABB_CCDD, 4'b0100);
        bus_read(A_CMP_LO, 32'h00BB_0020);

        // mtime wrap and write-over-tick.
        wr_mtime(1'b0, 32'hFFFF_FFFF, 4'hF);
        wr_mtime(1'b1, 32'hFFFF_FFFF, 4'hF);
        rd_mt(A_MT_LO);               // FFFFFFFF, wraps at this edge
        rd_mt(A_MT_HI);               // 0
        rd_mt(A_MT_LO);               // 1
        wr_mtime(1'b0, 32'h100, 4'hF);
        rd_mt(A_MT_LO);               // 0x100, no increment in write cycle
        wr_mtime(1'b0, 32'h0000_00AB, 4'b0001);
        rd_mt(A_MT_LO);
        rd_mt(A_MT_HI);

        // TICK_DIV=4 with a 3-cycle clock-enable gap.
        cke4 = 1'b1;
        repeat (5) step();
        bus_read4(A_MT_LO, 32'(e4 / 4));
        bus_read4(A_MT_LO, 32'(e4 / 4));
        step();
        cke4 = 1'b0;
        repeat (3) step();
        cke4 = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 4; i++) bus_read4(A_MT_LO, 32'(e4 / 4));
        bus_read4(A_MT_HI, 32'h0);
        step();

        // Reset in the middle of a read: response dropped, outputs at reset.
        bus_write(A_MSIP0, 32'h1, 4'hF);
        check("msip_pre_reset", {63'h0, msip}, 64'h1);
        addr   = A_MT_LO;
        wstrb  = 4'h0;
        avalid = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        avalid = 1'b0;
        check("rstmid_rvalid", {63'h0, rvalid}, 64'h0);
        check("rstmid_rdata",  {32'h0, rdata},  64'h0);
        check("rstmid_mtip",   {63'h0, mtip},   64'h0);
        check("rstmid_msip",   {63'h0, msip},   64'h0);
        check("rstmid_ready",  {63'h0, ready},  64'h1);
        @(negedge clk);
        check("rstmid_rvalid_neg", {63'h0, rvalid}, 64'h0);
        rst_n   = 1'b1;
        t_base  = t;
        mt_base = '0;
        rd_mt(A_MT_LO);
        rd_mt(A_MT_HI);
        bus_read(A_CMP_LO, 32'hFFFF_FFFF);
        bus_read(A_MSIP0, 32'h0);

        step();
        step();
        check("exp_q_drained",  64'(exp_q.size()),  64'h0);
        check("exp4_q_drained", 64'(exp4_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_clint.md
Name: iob_clint

Overview:
- Core-local interruptor on the CPU's CLINT IOb port. It is the slave stage directly downstream of the CPU CLINT request/response bus, which is currently tied off at the SoC top.
- Holds the 64-bit free-running machine timer `mtime`, per-hart `mtimecmp` registers and per-hart `msip` bits.
- Drives the machine timer interrupt and machine software interrupt lines back into the CPU.
- Register map follows the SiFive CLINT layout, so Linux/OpenSBI drivers work unmodified.

Parameters:
- ADDR_W, 16, IOb byte-address width seen by the block (offset inside the CLINT window).
- DATA_W, 32, IOb data width; only 32 is supported.
- N_CORES, 1, number of harts (1..8).
- TICK_DIV, 1, `clk_i` cycles per `mtime` increment (>=1); 1 means increment every enabled cycle.

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous, active-low reset
- cke_i  in  1  clock enable; when low, all state holds (including `mtime` and the prescaler)
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero = write, zero = read
- iob_rvalid_o  out  1  read data valid
- iob_rdata_o  out  DATA_W  read data
- iob_ready_o  out  1  request accepted
- mtip_o  out  N_CORES  machine timer interrupt pending, one bit per hart
- msip_o  out  N_CORES  machine software interrupt pending, one bit per hart

Behaviour:
- Interface decisions:
  - One clock `clk_i`.
  - Reset `arst_n_i` is asynchronous and active-low.
  - All flops reset on `arst_n_i` low, independent of `cke_i`.
- Reset values:
  - `iob_rvalid_o`=0, `iob_rdata_o`=0, `iob_ready_o`=1.
  - `mtime`=0, every `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF.
  - `msip`=0, `mtip_o`=0, `msip_o`=0, prescaler=0.
- Register map (word aligned; `iob_addr_i[1:0]` ignored):
  - `msip[h]`: 0x0000+4h. Bit 0 is R/W; bits 31:1 read 0.
  - `mtimecmp[h]`: low word at 0x4000+8h, high word at 0x4004+8h.
  - `mtime`: low word at 0xBFF8, high word at 0xBFFC.
  - Unmapped addresses (including harts >= N_CORES): reads return 0, writes are ignored, the handshake still completes.
- Handshake:
  - `iob_ready_o` is held at 1; every cycle with `iob_avalid_i`=1 and `cke_i`=1 is an accepted request.
  - Read: `iob_rvalid_o`=1 for exactly one cycle, the cycle after acceptance. `iob_rdata_o` is registered and holds its value until the next read.
  - Back-to-back reads give back-to-back `rvalid`.
  - Write: no `rvalid` is generated. Takes effect on the register at the accepting clock edge; visible to a read accepted the next cycle.
  - Byte strobes apply per byte to the addressed 32-bit word.
- Timebase:
  - Prescaler counts 0..TICK_DIV-1 on `cke_i`. On wrap, `mtime` <= `mtime`+1, 64-bit modulo (FFFF_FFFF_FFFF_FFFF -> 0).
  - TICK_DIV=1: `mtime` increments every enabled cycle.
  - A bus write to either `mtime` half in the same cycle as a tick wins: that half takes the written bytes, and the other half keeps its old value with no carry applied. The prescaler is not reset by `mtime` writes.
  - A read of `mtime` returns the value before that cycle's update.
- Interrupts:
  - `mtip_o[h]` is registered: `mtip_o[h]` <= (`mtime` >= `mtimecmp[h]`), unsigned 64-bit compare on current register values. One-cycle latency after any change to `mtime` or `mtimecmp`.
  - Writing `mtimecmp` above `mtime` clears `mtip` on the cycle after the following edge.
  - `msip_o` is driven directly from the `msip` flops.
- Simultaneous events: bus write to `mtimecmp` plus `mtime` tick in the same cycle → both update, and the compare uses the new values on the next edge.
- Reset mid-transaction: a pending `rvalid` is dropped; the master retries.

Decomposition:
- Package `iob_clint_pkg`, holding:
  - Offsets `MSIP_BASE`=0x0000, `MTIMECMP_BASE`=0x4000, `MTIME_LO`=0xBFF8, `MTIME_HI`=0xBFFC.
  - `MTIME_W`=64.
  - A byte-strobe merge function for a 32-bit word.
- Sub-module `iob_clint_timebase`: prescaler plus 64-bit `mtime` counter, with write-override inputs (lo/hi data, lo/hi strobes) and an `mtime` output.
- Top level keeps address decode, `msip`/`mtimecmp` banks, compare flops and the read mux.

Test Plan:
- Reset, TICK_DIV=1 → `mtime` reads 0 then increments by 1 per cycle; `mtimecmp0` reads FFFFFFFF/FFFFFFFF; `mtip_o`=0, `msip_o`=0.
- Write `mtimecmp0` lo=0x20, hi=0 while `mtime`<0x20 → `mtip_o[0]` rises exactly one cycle after `mtime` reaches 0x20; writing hi=1 clears it one cycle later.
- Write 0x1 to 0x0000 → `msip_o[0]`=1 the next cycle; write with `wstrb`=0001 and data 0 → cleared; strobe 0010 with data 0 → no change.
- Write `mtime` lo=0xFFFFFFFF, hi=0xFFFFFFFF, tick → `mtime` wraps to 0; write lo in a tick cycle → written value, no increment that cycle.
- TICK_DIV=4 with `cke_i` low for 3 cycles mid-count → `mtime` increments every 4 enabled cycles only.
- Read unmapped 0x8000 and hart-1 `msip` with N_CORES=1 → `rvalid` next cycle, data 0; assert reset during a read → no `rvalid`, all outputs at reset values.
